// File: rtl/ldpc_3gpp_dec_mem_state_ctrl_pkg.sv
// ldpc_3gpp_dec_mem_state_ctrl_pkg: shared decoder types and constants for the
// node-state memory sequencer and its beat strobe generator.
package ldpc_3gpp_dec_mem_state_ctrl_pkg;

    localparam int cZC_W   = 9;
    localparam int cWB_LAT = 3;

    typedef logic [cZC_W-1:0] hb_zc_t;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

endpackage

// File: rtl/ldpc_3gpp_dec_mem_state_ctrl_strb_gen.sv
// ldpc_3gpp_dec_strb_gen: row/zc beat counters with sof/sop/eop/eof decode of the
// beat issued this tick; iclear restarts the frame at beat 0 in the same tick.
module ldpc_3gpp_dec_strb_gen
    import ldpc_3gpp_dec_mem_state_ctrl_pkg::*;
#(
    parameter int pROW_W = 5
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iclkena,
    input  logic              iclear,
    input  logic              istep,
    input  logic [pROW_W-1:0] iused_row,
    input  hb_zc_t            iused_zc,
    output strb_t             ostrb
);

    logic [pROW_W-1:0] row_cnt, row_cur;
    hb_zc_t            zc_cnt, zc_cur;
    logic              row_last, zc_last;

    always_comb begin
        row_cur   = iclear ? '0 : row_cnt;
        zc_cur    = iclear ? '0 : zc_cnt;
        row_last  = row_cur == iused_row - pROW_W'(1);
        zc_last   = zc_cur == iused_zc - hb_zc_t'(1);
        ostrb.sof = (row_cur == '0) & (zc_cur == '0);
        ostrb.sop = row_cur == '0;
        ostrb.eop = row_last;
        ostrb.eof = row_last & zc_last;
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            row_cnt <= '0;
            zc_cnt  <= '0;
        end else if (iclkena) begin
            if (istep) begin
                row_cnt <= row_last ? '0 : row_cur + pROW_W'(1);
                zc_cnt  <= !row_last ? zc_cur : zc_last ? '0 : zc_cur + hb_zc_t'(1);
            end else if (iclear) begin
                row_cnt <= '0;
                zc_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/ldpc_3gpp_dec_mem_state_ctrl.sv
// ldpc_3gpp_dec_mem_state_ctrl: sequences per-iteration state-memory read frames
// and holds each new iteration until the previous write-back has settled.
module ldpc_3gpp_dec_mem_state_ctrl
    import ldpc_3gpp_dec_mem_state_ctrl_pkg::*;
#(
    parameter int pROW_W  = 5,
    parameter int pITER_W = 8,
    parameter int pWB_LAT = cWB_LAT
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               iclkena,
    input  logic               istart,
    input  hb_zc_t             iused_zc,
    input  logic [pROW_W-1:0]  iused_row,
    input  logic [pITER_W-1:0] inum_iter,
    input  logic               ihold,
    input  logic               iwrite,
    input  strb_t              iwstrb,
    output logic               oread,
    output logic               orstart,
    output logic               orval,
    output strb_t              orstrb,
    output logic               ofirst_iter,
    output logic [pITER_W-1:0] oiter,
    output logic               obusy,
    output logic               odone
);

    localparam logic [1:0] cIDLE    = 2'd0;
    localparam logic [1:0] cREAD    = 2'd1;
    localparam logic [1:0] cWAIT_WB = 2'd2;
    localparam logic [1:0] cDONE    = 2'd3;
    localparam int         cCNT_W   = $clog2(pWB_LAT + 1);

    logic [1:0]         state, state_nxt;
    logic [pROW_W-1:0]  used_row, cur_row;
    hb_zc_t             used_zc, cur_zc;
    logic [pITER_W-1:0] last_iter, iter_nxt;
    logic [cCNT_W-1:0]  wb_cnt;
    logic               sticky, wr_eof, launch_idle, launch_next, wb_ok, finish;
    logic               in_read, emit, busy_nxt;
    strb_t              strb;
    logic               unused_wstrb;

    assign unused_wstrb = ^{iwstrb.sof, iwstrb.sop, iwstrb.eop};

    always_comb begin
        wr_eof      = iwrite & iwstrb.eof;
        launch_idle = (state == cIDLE) & istart;
        wb_ok       = (state == cWAIT_WB) & (wb_cnt == cCNT_W'(pWB_LAT));
        launch_next = wb_ok & (oiter != last_iter);
        finish      = wb_ok & (oiter == last_iter);
        in_read     = (state == cREAD) | launch_idle | launch_next;
        emit        = in_read & ~ihold;
        cur_row     = launch_idle ? iused_row : used_row;
        cur_zc      = launch_idle ? iused_zc : used_zc;
        iter_nxt    = launch_idle ? '0 : launch_next ? oiter + pITER_W'(1) : oiter;
        state_nxt   = in_read ? ((emit & strb.eof) ? cWAIT_WB : cREAD) :
                      finish ? cDONE : (state == cDONE) ? cIDLE : state;
        busy_nxt    = state_nxt != cIDLE;
    end

    ldpc_3gpp_dec_strb_gen #(
        .pROW_W    (pROW_W)
    ) u_strb_gen (
        .iclk      (iclk),
        .ireset_n  (ireset_n),
        .iclkena   (iclkena),
        .iclear    (launch_idle | launch_next),
        .istep     (emit),
        .iused_row (cur_row),
        .iused_zc  (cur_zc),
        .ostrb     (strb)
    );

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state       <= cIDLE;
            used_row    <= '0;
            used_zc     <= '0;
            last_iter   <= '0;
            sticky      <= 1'b0;
            wb_cnt      <= '0;
            oread       <= 1'b0;
            orstart     <= 1'b0;
            orval       <= 1'b0;
            orstrb      <= '0;
            ofirst_iter <= 1'b0;
            oiter       <= '0;
            obusy       <= 1'b0;
            odone       <= 1'b0;
        end else if (iclkena) begin
            state <= state_nxt;
            if (launch_idle) begin
                used_row  <= iused_row;
                used_zc   <= iused_zc;
                last_iter <= (inum_iter == '0) ? '0 : inum_iter - pITER_W'(1);
            end
            // an eof write landing while still reading is remembered for WAIT_WB
            sticky      <= (launch_idle | wb_ok) ? 1'b0 : sticky | ((state == cREAD) & wr_eof);
            wb_cnt      <= (state != cWAIT_WB || wb_ok) ? '0 :
                           (wb_cnt != '0 || sticky || wr_eof) ? wb_cnt + cCNT_W'(1) : '0;
            oread       <= emit & (iter_nxt != '0);
            orstart     <= emit & strb.sof;
            orval       <= emit;
            if (emit) orstrb <= strb;
            ofirst_iter <= busy_nxt & (iter_nxt == '0);
            oiter       <= iter_nxt;
            obusy       <= busy_nxt;
            odone       <= finish;
        end
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_mem_state_ctrl.sv
// tb_ldpc_3gpp_dec_mem_state_ctrl: directed frame table, hand sequences and a
// randomized run against a beat-index reference model.
module tb_ldpc_3gpp_dec_mem_state_ctrl;
    import ldpc_3gpp_dec_mem_state_ctrl_pkg::*;

    localparam int P_IDLE = 0, P_READ = 1, P_WAIT = 2, P_DONE = 3;

    logic       iclk = 1'b0, ireset_n = 1'b0, iclkena = 1'b1, istart = 1'b0;
    logic       ihold = 1'b0, iwrite = 1'b0;
    hb_zc_t     iused_zc = 1;
    logic [4:0] iused_row = 1;
    logic [7:0] inum_iter = 1;
    strb_t      iwstrb = '0;
    logic       oread, orstart, orval, ofirst_iter, obusy, odone;
    strb_t      orstrb;
    logic [7:0] oiter;

    always #5 iclk = ~iclk;

    ldpc_3gpp_dec_mem_state_ctrl dut (
        .iclk        (iclk),
        .ireset_n    (ireset_n),
        .iclkena     (iclkena),
        .istart      (istart),
        .iused_zc    (iused_zc),
        .iused_row   (iused_row),
        .inum_iter   (inum_iter),
        .ihold       (ihold),
        .iwrite      (iwrite),
        .iwstrb      (iwstrb),
        .oread       (oread),
        .orstart     (orstart),
        .orval       (orval),
        .orstrb      (orstrb),
        .ofirst_iter (ofirst_iter),
        .oiter       (oiter),
        .obusy       (obusy),
        .odone       (odone)
    );

    int    total = 0, bad = 0, cyc = 0;
    int    m_ph, m_k, m_r, m_z, m_n, m_iter, m_seen, m_tick;
    bit    m_sticky;
    logic  e_read, e_rstart, e_rval, e_done;
    strb_t e_strb;

    typedef struct {
        int zc, row, iter, d;
        int beats, reads, done_at, sop_mask, eof_idx;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_k = 0; m_iter = 0; m_seen = -1; m_sticky = 0;
        e_read = 0; e_rstart = 0; e_rval = 0; e_done = 0; e_strb = '0;
    endtask

    // frame position is a plain beat index; strobes come from its row/zc split
    task automatic model_step();
        bit launch, wr;
        int row;
        if (!iclkena) return;
        m_tick++;
        wr = iwrite && iwstrb.eof;
        launch = 0;
        e_done = 0;
        if (m_ph == P_READ && wr) m_sticky = 1;
        if (m_ph == P_IDLE && istart) begin
            m_r = int'(iused_row); m_z = int'(iused_zc);
            m_n = (inum_iter == 0) ? 1 : int'(inum_iter);
            m_iter = 0; m_k = 0; m_sticky = 0; launch = 1;
        end else if (m_ph == P_WAIT) begin
            if (m_seen < 0) begin
                if (m_sticky || wr) m_seen = m_tick;
            end else if (m_tick == m_seen + cWB_LAT) begin
                m_sticky = 0;
                if (m_iter == m_n - 1) begin
                    m_ph = P_DONE; e_done = 1;
                end else begin
                    m_iter++; m_k = 0; launch = 1;
                end
            end
        end else if (m_ph == P_DONE) m_ph = P_IDLE;
        e_rval = 0; e_read = 0; e_rstart = 0;
        if (m_ph == P_READ || launch) begin
            m_ph = P_READ;
            if (!ihold) begin
                row = m_k % m_r;
                e_strb.sof = m_k == 0;
                e_strb.sop = row == 0;
                e_strb.eop = row == m_r - 1;
                e_strb.eof = m_k == m_r * m_z - 1;
                e_rval = 1; e_read = m_iter != 0; e_rstart = m_k == 0;
                m_k++;
                if (m_k == m_r * m_z) begin
                    m_ph = P_WAIT; m_seen = -1;
                end
            end
        end
    endtask

    task automatic step();
        if (!ireset_n) model_reset(); else model_step();
        @(posedge iclk);
        #1;
        cyc++;
        check($sformatf("cycle %0d outputs", cyc),
              32'({oread, orstart, orval, orstrb, ofirst_iter, oiter, obusy, odone}),
              32'({e_read, e_rstart, e_rval, e_strb, (m_ph != P_IDLE) && (m_iter == 0),
                   8'(m_iter), m_ph != P_IDLE, e_done}));
    endtask

    task automatic drain(input int d, input int t0, output int done_at, output int beats,
                         output int reads, output int sopm, output int eofi);
        int wr_at = -1;
        done_at = -1; beats = 0; reads = 0; sopm = 0; eofi = -1;
        for (int n = 0; n < 600 && done_at < 0; n++) begin
            if (orval) begin
                if (oiter == 0 && beats < 32 && orstrb.sop) sopm |= 1 << beats;
                if (oiter == 0 && orstrb.eof) eofi = beats;
                if (orstrb.eof) wr_at = cyc + d;
                beats++;
            end
            reads += int'(oread);
            if (odone) done_at = cyc - t0;
            iwrite = cyc == wr_at;
            iwstrb = {3'b000, iwrite};
            step();
        end
        iwrite = 0;
        iwstrb = '0;
    endtask

    task automatic run_entry(input int idx, input vec_t v);
        int t0, done_at, beats, reads, sopm, eofi;
        iused_zc = hb_zc_t'(v.zc); iused_row = 5'(v.row); inum_iter = 8'(v.iter);
        istart = 1; t0 = cyc;
        step();
        istart = 0;
        drain(v.d, t0, done_at, beats, reads, sopm, eofi);
        check($sformatf("vec%0d beats", idx), beats, v.beats);
        check($sformatf("vec%0d reads", idx), reads, v.reads);
        check($sformatf("vec%0d done time", idx), done_at, v.done_at);
        check($sformatf("vec%0d sop mask", idx), sopm, v.sop_mask);
        check($sformatf("vec%0d eof beat", idx), eofi, v.eof_idx);
    endtask

    task automatic hold_seq();
        strb_t exp_s;
        int beats = 0, wr_at = -1, hcnt = 0;
        bit fin = 0;
        iused_zc = 2; iused_row = 4; inum_iter = 1; istart = 1;
        step();
        istart = 0;
        for (int n = 0; n < 100 && !fin; n++) begin
            if (orval) begin
                exp_s = {beats == 0, beats % 4 == 0, beats % 4 == 3, beats == 7};
                check($sformatf("hold beat %0d strb", beats), 32'(orstrb), 32'(exp_s));
                if (orstrb.eof) wr_at = cyc + 1;
                beats++;
            end
            fin = odone;
            ihold = beats >= 2 && hcnt < 3;
            if (ihold) hcnt++;
            iwrite = cyc == wr_at;
            iwstrb = {3'b000, iwrite};
            step();
        end
        ihold = 0; iwrite = 0; iwstrb = '0;
        check("hold beat count", beats, 8);
        check("hold done seen", 32'(fin), 1);
    endtask

    initial begin
        int t0, done_at, beats, reads, sopm, eofi;
        vecs[0] = '{3, 2, 1, 5,  6,  0, 15, 'h15, 5};
        vecs[1] = '{3, 2, 3, 2, 18, 12, 34, 'h15, 5};
        vecs[2] = '{4, 1, 1, 1,  4,  0,  9, 'hF,  3};
        vecs[3] = '{1, 1, 0, 1,  1,  0,  6, 'h1,  0};
        vecs[4] = '{2, 4, 2, 3, 16,  8, 29, 'h11, 7};
        vecs[5] = '{1, 5, 2, 1, 10,  5, 19, 'h1,  4};
        model_reset();
        m_tick = 0;
        step();
        step();
        ireset_n = 1;
        step();
        check("reset outputs", 32'({oread, orstart, orval, orstrb, ofirst_iter, oiter, obusy, odone}), 0);

        foreach (vecs[i]) run_entry(i, vecs[i]);

        hold_seq();
        step();

        // eof write arrives while the frame is still being read
        iused_zc = 2; iused_row = 2; inum_iter = 1; istart = 1; t0 = cyc;
        step();
        istart = 0;
        step();
        iwrite = 1; iwstrb = {3'b000, 1'b1};
        step();
        iwrite = 0; iwstrb = '0;
        drain(-1000, t0, done_at, beats, reads, sopm, eofi);
        check("early eof done time", done_at, 8);

        // reset in the middle of a read frame, then a clean restart
        iused_zc = 3; iused_row = 3; inum_iter = 2; istart = 1;
        step();
        istart = 0;
        step();
        step();
        ireset_n = 0;
        #1;
        check("async reset outputs", 32'({oread, orstart, orval, orstrb, ofirst_iter, oiter, obusy, odone}), 0);
        step();
        ireset_n = 1;
        step();
        iused_zc = 2; iused_row = 1; inum_iter = 1; istart = 1; t0 = cyc;
        step();
        istart = 0;
        check("post-reset first beat", 32'({orval, orstart, orstrb, obusy}), 32'b1111101);
        drain(2, t0, done_at, beats, reads, sopm, eofi);
        check("post-reset done time", done_at, 8);

        for (int n = 0; n < 4000; n++) begin
            iclkena   = $urandom_range(0, 9) != 0;
            istart    = $urandom_range(0, 3) == 0;
            ihold     = $urandom_range(0, 3) == 0;
            iwrite    = $urandom_range(0, 7) == 0;
            iwstrb    = strb_t'($urandom_range(0, 15));
            iused_zc  = hb_zc_t'($urandom_range(1, 4));
            iused_row = 5'($urandom_range(1, 5));
            inum_iter = 8'($urandom_range(0, 3));
            if (n == 2000) ireset_n = 0;
            step();
            ireset_n = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldpc_3gpp_dec_mem_state_ctrl.md
# ldpc_3gpp_dec_mem_state_ctrl

Sequencer that drives the read and write-back request streams of the decoder node-state memory. It produces per-iteration read frames of `iused_zc` packets × `iused_row` beats and gates each new iteration on write-back completion, so the vnode pipeline never reads a state before it has been rewritten. It sits between the decoder iteration control and the state-memory block's read port, and observes that block's write port.

## Interface
Parameters:
- pROW_W, 5, width of row-beat count (`iused_row`).
- pITER_W, 8, width of iteration count.
- pWB_LAT, 3, state RAM write latency in ticks (address gen 2 + RAM 1).

Ports:
- iclk  in  1  clock.
- ireset_n  in  1  asynchronous, active-low reset.
- iclkena  in  1  clock enable; all state frozen when low.
- istart  in  1  frame start; accepted only in IDLE.
- iused_zc  in  hb_zc_t  packets per frame (≥1); sampled at istart.
- iused_row  in  pROW_W  beats per packet (≥1); sampled at istart.
- inum_iter  in  pITER_W  iterations; 0 treated as 1; sampled at istart.
- ihold  in  1  vnode backpressure; freezes read stream.
- iwrite  in  1  monitored state-memory write enable.
- iwstrb  in  strb_t  monitored write strobe (eof used).
- oread  out  1  state-memory read enable.
- orstart  out  1  high on first beat of each iteration.
- orval  out  1  beat valid to vnode.
- orstrb  out  strb_t  sof/sop/eop/eof of read stream.
- ofirst_iter  out  1  high during iteration 0 beats (states invalid, vnode uses zero state).
- oiter  out  pITER_W  current iteration index.
- obusy  out  1  high outside IDLE.
- odone  out  1  one-tick pulse after last write-back settles.

## Operation
- FSM: IDLE → READ → WAIT_WB → (READ if iterations remain, else DONE) → IDLE.
- IDLE: on istart latch parameters, clear counters, oiter=0, go READ.
- READ: each enabled tick with ihold=0 emits one beat: orval=1, oread=~ofirst_iter. Beat counter row_cnt 0..iused_row-1 inner, zc_cnt 0..iused_zc-1 outer.
  - sop: row_cnt==0; eop: row_cnt==iused_row-1; sof: sop & zc_cnt==0; eof: eop & zc_cnt==iused_zc-1.
  - orstart = sof beat. After eof beat go WAIT_WB.
- ihold=1 in READ: orval=oread=0, strobe register holds last value, counters frozen.
- WAIT_WB: wait for iwrite & iwstrb.eof, then count pWB_LAT ticks; then oiter+1 and READ, or DONE if oiter==inum_iter-1.
- eof write seen during READ (early vnode) is captured in a sticky flag and honoured in WAIT_WB.
- DONE: odone=1 one tick, go IDLE. istart ignored outside IDLE.
- Counter compares use latched values; iused_row=1 makes every beat sop&eop; iused_zc=1 makes sof on beat 0 only.

## Timing
- Reset: state IDLE; oread, orstart, orval, obusy, odone, ofirst_iter = 0; orstrb = '0; oiter = 0.
- All outputs registered. istart at tick T → first beat (sof, orstart) at T+1; obusy high from T+1.
- Frame length with no hold: iused_zc·iused_row ticks, back-to-back beats.
- Write eof at tick E in WAIT_WB → next iteration sof at E+pWB_LAT+1; last iteration → odone at E+pWB_LAT+1, obusy low at E+pWB_LAT+2.
- iclkena low: no state change, outputs hold.
- Reset mid-frame: immediate return to reset values; sticky flag cleared.

## Structure
- strb_t, hb_zc_t and pWB_LAT default come from the shared decoder types/constants package; no new package types.
- Single module; counters and FSM inline. Beat strobe generation may be a sub-module `ldpc_3gpp_dec_strb_gen` (row/zc counters + strobe decode), reusable by the cnode address path.

## Test plan
- iused_zc=3, iused_row=2, inum_iter=1, write eof 5 ticks after read eof → 6 beats sop on 0/2/4, eof on beat 5, oread=0 all beats, odone 4 ticks after write eof.
- inum_iter=3 → iterations 1,2 have oread=1, oiter=1,2, sof gap = pWB_LAT+1 after each write eof.
- ihold high on beats 2–4 of iused_zc=2, iused_row=4 → no beat lost/duplicated, strobes resume at beat 2.
- iused_row=1, iused_zc=4 → every beat sop&eop, eof on beat 3.
- Write eof arriving during READ → WAIT_WB exits after pWB_LAT ticks without further eof.
- ireset_n low mid-READ, then istart → all outputs reset, clean new frame from sof.
